// File: rtl/mas_pkg.sv
// Shared op codes and FSM states for the streaming modular accumulator.
package mas_pkg;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_LOAD = 2'b10,
        OP_NOP  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ACC  = 2'b01,
        DONE = 2'b10
    } state_e;

endpackage

// File: rtl/mas_mod_step.sv
// One modular fold step: acc op d, corrected once into [0, Q-1].
module mas_mod_step
    import mas_pkg::*;
#(
    parameter int W = 5
) (
    input  logic signed [W:0]   acc_i,
    input  logic signed [W-1:0] d_i,
    input  logic [1:0]          op_i,
    input  logic signed [W-1:0] q_i,
    output logic signed [W:0]   acc_o,
    output logic                rng_err_o
);

    logic signed [W:0] d_x;
    logic signed [W:0] q_x;
    logic signed [W:0] t;

    assign d_x = {d_i[W-1], d_i};
    assign q_x = {q_i[W-1], q_i};

    always_comb begin
        t = acc_i;
        unique case (op_i)
            OP_ADD:  t = acc_i + d_x;
            OP_SUB:  t = acc_i - d_x;
            OP_LOAD: t = d_x;
            default: t = acc_i;
        endcase
    end

    always_comb begin
        acc_o = t;
        if (t >= q_x) begin
            acc_o = t - q_x;
        end else if (t < 0) begin
            acc_o = t + q_x;
        end
    end

    assign rng_err_o = (op_i != OP_NOP) && ((d_i < 0) || (d_i >= q_i));

endmodule

// File: rtl/mas_stream_accum.sv
// Frame-based modular accumulator: folds a stream of operands mod Q,
// emits one result (value, length, error) per frame.
module mas_stream_accum
    import mas_pkg::*;
#(
    parameter int W       = 5,
    parameter int MAX_LEN = 16,
    parameter int LEN_W   = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [W-1:0] in_data,
    input  logic [1:0]          in_op,
    input  logic                in_last,
    input  logic signed [W-1:0] q_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [W-2:0]        out_data,
    output logic [LEN_W-1:0]    out_len,
    output logic                out_err
);

    state_e              state_q;
    logic signed [W:0]   acc_q;
    logic signed [W-1:0] q_q;
    logic [LEN_W-1:0]    cnt_q;
    logic                err_q;
    logic                out_valid_q;
    logic [W-2:0]        out_data_q;
    logic [LEN_W-1:0]    out_len_q;
    logic                out_err_q;

    logic                first;
    logic                accept;
    logic signed [W-1:0] q_use;
    logic signed [W:0]   acc_use;
    logic signed [W:0]   acc_d;
    logic                rng_err;
    logic [LEN_W-1:0]    cnt_d;
    logic                hit_max;
    logic                frame_end;
    logic                err_d;

    assign first    = (state_q == IDLE);
    assign in_ready = rst_n && (state_q != DONE);
    assign accept   = in_valid && in_ready;

    // The first beat uses the fresh modulus and starts from a zero accumulator.
    assign q_use   = first ? q_in : q_q;
    assign acc_use = first ? '0 : acc_q;

    mas_mod_step #(.W(W)) u_step (
        .acc_i     (acc_use),
        .d_i       (in_data),
        .op_i      (in_op),
        .q_i       (q_use),
        .acc_o     (acc_d),
        .rng_err_o (rng_err)
    );

    assign cnt_d     = first ? LEN_W'(1) : cnt_q + LEN_W'(1);
    assign hit_max   = (cnt_d == LEN_W'(MAX_LEN));
    assign frame_end = in_last || hit_max;

    always_comb begin
        err_d = rng_err || (hit_max && !in_last);
        if (first) begin
            err_d = err_d || (q_in <= 0);
        end else begin
            err_d = err_d || err_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            q_q         <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_len_q   <= '0;
            out_err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE, ACC: begin
                    if (accept) begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_d;
                        err_q <= err_d;
                        if (first) begin
                            q_q <= q_in;
                        end
                        if (frame_end) begin
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                            out_data_q  <= (q_use <= 0) ? '0 : acc_d[W-2:0];
                            out_len_q   <= cnt_d;
                            out_err_q   <= err_d;
                        end else begin
                            state_q <= ACC;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_len   = out_len_q;
    assign out_err   = out_err_q;

endmodule
